jk_bank_controller: RTL and testbench

- Command-driven sequencer for a bank of WIDTH JK flip-flops.
- Takes one command at a time over a valid/ready handshake and generates the per-bit J/K drive each cycle:
  - single-cycle ops: load, set, clear, toggle under mask;
  - multi-cycle ops: count up or down by N steps.
- Owns the bank and exposes its state.
- Sits between a host/command source and any logic consuming the register value.

---
 rtl/jk_bank_controller_pkg.sv | 33 +++
 rtl/jk_bank.sv | 37 +++
 rtl/jk_bank_controller.sv | 169 ++++++++++++++++
 tb/tb_jk_bank_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank_controller_pkg
//  Description : Shared opcodes, FSM state encoding and helpers for the
//                JK flip-flop bank controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_bank_controller_pkg;

   // Command opcodes (3-bit field)
   localparam logic [2:0] OP_NOP        = 3'd0;
   localparam logic [2:0] OP_LOAD       = 3'd1;
   localparam logic [2:0] OP_SET        = 3'd2;
   localparam logic [2:0] OP_CLEAR      = 3'd3;
   localparam logic [2:0] OP_TOGGLE     = 3'd4;
   localparam logic [2:0] OP_COUNT_UP   = 3'd5;
   localparam logic [2:0] OP_COUNT_DOWN = 3'd6;
   localparam logic [2:0] OP_RSVD       = 3'd7;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_COUNT = 2'd2
   } state_t;

   // True for the two multi-cycle counting opcodes
   function automatic logic is_count_op(input logic [2:0] op);
      return (op == OP_COUNT_UP) || (op == OP_COUNT_DOWN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank
//  Description : WIDTH-wide vector of JK flip-flops. No reset: the controller
//                clears the bank by driving K high during reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_bank #(
   parameter int WIDTH = 8
) (
   input  logic             i_Clk,
   input  logic [WIDTH-1:0] i_J,
   input  logic [WIDTH-1:0] i_K,
   output logic [WIDTH-1:0] o_Q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Per-bit JK characteristic equation: Q+ = J&~Q | ~K&Q
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_comb begin
            q_d[gi] = (i_J[gi] & ~q_q[gi]) | (~i_K[gi] & q_q[gi]);
         end
      end
   endgenerate

   // Bank state register
   always_ff @(posedge i_Clk) begin
      q_q <= q_d;
   end

   assign o_Q = q_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_controller.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank_controller
//  Description : Command-driven sequencer for a bank of JK flip-flops.
//                Single-cycle load/set/clear/toggle under mask, multi-cycle
//                count up/down by N steps, valid/ready command handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_controller
   import jk_bank_controller_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_Cmd_Valid,
   output logic             o_Cmd_Ready,
   input  logic [2:0]       i_Cmd_Op,
   input  logic [WIDTH-1:0] i_Cmd_Data,
   input  logic [CNT_W-1:0] i_Cmd_Count,
   output logic [WIDTH-1:0] o_J,
   output logic [WIDTH-1:0] o_K,
   output logic [WIDTH-1:0] o_Q,
   output logic             o_Busy,
   output logic             o_Done
);

   state_t           state_q,  state_d;
   logic [2:0]       op_q,     op_d;
   logic [WIDTH-1:0] data_q,   data_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             done_q,   done_d;

   logic [WIDTH-1:0] tgl_up;
   logic [WIDTH-1:0] tgl_dn;

   // Next-state, command latch and handshake/status decode
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      remain_d    = remain_q;
      done_d      = 1'b0;
      o_Cmd_Ready = 1'b0;
      o_Busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_Cmd_Ready = 1'b1;
            if (i_Cmd_Valid) begin
               op_d     = i_Cmd_Op;
               data_d   = i_Cmd_Data;
               remain_d = i_Cmd_Count;
               // A zero-length count degenerates to a one-cycle NOP in EXEC
               if (is_count_op(i_Cmd_Op) && (i_Cmd_Count != '0)) begin
                  state_d = ST_COUNT;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            o_Busy  = 1'b1;
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         ST_COUNT: begin
            o_Busy   = 1'b1;
            remain_d = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller registers; reset aborts any command without a done pulse
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_NOP;
         data_q   <= '0;
         remain_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         remain_q <= remain_d;
         done_q   <= done_d;
      end
   end

   // Ripple toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down)
   always_comb begin
      tgl_up    = '0;
      tgl_dn    = '0;
      tgl_up[0] = 1'b1;
      tgl_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         tgl_up[i] = tgl_up[i-1] &  o_Q[i-1];
         tgl_dn[i] = tgl_dn[i-1] & ~o_Q[i-1];
      end
   end

   // J/K drive: K all-ones during reset clears the resetless bank
   always_comb begin
      o_J = '0;
      o_K = '0;
      if (i_Rst) begin
         o_K = '1;
      end else begin
         case (state_q)
            ST_EXEC: begin
               case (op_q)
                  OP_LOAD: begin
                     o_J = data_q;
                     o_K = ~data_q;
                  end
                  OP_SET: begin
                     o_J = data_q;
                  end
                  OP_CLEAR: begin
                     o_K = data_q;
                  end
                  OP_TOGGLE: begin
                     o_J = data_q;
                     o_K = data_q;
                  end
                  default: begin
                     o_J = '0;
                     o_K = '0;
                  end
               endcase
            end
            ST_COUNT: begin
               if (op_q == OP_COUNT_DOWN) begin
                  o_J = tgl_dn;
                  o_K = tgl_dn;
               end else begin
                  o_J = tgl_up;
                  o_K = tgl_up;
               end
            end
            default: begin
               o_J = '0;
               o_K = '0;
            end
         endcase
      end
   end

   assign o_Done = done_q;

   jk_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .i_Clk (i_Clk),
      .i_J   (o_J),
      .i_K   (o_K),
      .o_Q   (o_Q)
   );

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_bank_controller
//  Description : Self-checking bench for jk_bank_controller with directed
//                and randomized commands against an arithmetic bank model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_controller;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic [7:0] cmd_count;
   logic [7:0] j_out;
   logic [7:0] k_out;
   logic [7:0] q_out;
   logic       busy;
   logic       done;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] q_model  = 8'h00;

   jk_bank_controller #(
      .WIDTH (8),
      .CNT_W (8)
   ) dut (
      .i_Clk       (clk),
      .i_Rst       (rst),
      .i_Cmd_Valid (cmd_valid),
      .o_Cmd_Ready (cmd_ready),
      .i_Cmd_Op    (cmd_op),
      .i_Cmd_Data  (cmd_data),
      .i_Cmd_Count (cmd_count),
      .o_J         (j_out),
      .o_K         (k_out),
      .o_Q         (q_out),
      .o_Busy      (busy),
      .o_Done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the bench can never hang
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Idle cycles: bank holds, no done, ready, J=K=0
   task automatic idle(input int n);
      cmd_valid = 1'b0;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("idle_done",  done,      0);
         chk("idle_busy",  busy,      0);
         chk("idle_ready", cmd_ready, 1);
         chk("idle_jk",    {j_out, k_out}, 16'h0000);
         chk("idle_q",     q_out,     q_model);
      end
   endtask

   // Issue one command from a negedge where the controller is ready; returns
   // at the negedge of the done cycle so the next command is accepted there.
   task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input logic [7:0] cnt);
      logic [7:0] q0;
      logic [7:0] qe;
      logic [7:0] tg;
      logic [7:0] jx;
      logic [7:0] kx;
      logic [7:0] res;
      bit         is_cnt;
      int         steps;
      chk("ready_pre", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
      q0        = q_model;
      is_cnt    = ((op == 3'd5) || (op == 3'd6)) && (cnt != 8'd0);
      steps     = is_cnt ? int'(cnt) : 1;
      @(posedge clk);
      @(negedge clk);
      for (int s = 1; s <= steps; s++) begin
         if (is_cnt) begin
            if (op == 3'd5) begin
               qe = q0 + 8'(s - 1);
               tg = qe ^ (qe + 8'd1);
            end else begin
               qe = q0 - 8'(s - 1);
               tg = qe ^ (qe - 8'd1);
            end
            jx = tg;
            kx = tg;
         end else begin
            qe = q0;
            case (op)
               3'd1:    begin jx = data;  kx = ~data; end
               3'd2:    begin jx = data;  kx = 8'h00; end
               3'd3:    begin jx = 8'h00; kx = data;  end
               3'd4:    begin jx = data;  kx = data;  end
               default: begin jx = 8'h00; kx = 8'h00; end
            endcase
         end
         chk("busy",    busy,      1);
         chk("ready",   cmd_ready, 0);
         chk("done_lo", done,      0);
         chk("q_step",  q_out,     qe);
         chk("j_drive", j_out,     jx);
         chk("k_drive", k_out,     kx);
         // Junk on the command bus while busy must be ignored
         cmd_valid = 1'b1;
         cmd_op    = 3'($urandom);
         cmd_data  = 8'($urandom);
         cmd_count = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      case (op)
         3'd1:    res = data;
         3'd2:    res = q0 | data;
         3'd3:    res = q0 & ~data;
         3'd4:    res = q0 ^ data;
         3'd5:    res = q0 + cnt;
         3'd6:    res = q0 - cnt;
         default: res = q0;
      endcase
      q_model = res;
      chk("q_result",   q_out,     q_model);
      chk("done_pulse", done,      1);
      chk("busy_end",   busy,      0);
      chk("ready_done", cmd_ready, 1);
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 8'h00;
      cmd_count = 8'h00;

      // Reset and idle
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_q",  q_out, 8'h00);
      chk("rst_j",  j_out, 8'h00);
      chk("rst_k",  k_out, 8'hFF);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_busy",  busy,      0);
      chk("post_rst_done",  done,      0);
      chk("post_rst_jk",    {j_out, k_out}, 16'h0000);
      chk("post_rst_q",     q_out,     8'h00);

      // Single-cycle ops, back to back, then one idle to see a single done
      do_cmd(3'd1, 8'hA5, 8'd0);
      chk("load_a5", q_out, 8'hA5);
      do_cmd(3'd2, 8'h0F, 8'd0);
      chk("set_0f", q_out, 8'hAF);
      do_cmd(3'd3, 8'hF0, 8'd0);
      chk("clear_f0", q_out, 8'h0F);
      do_cmd(3'd4, 8'hFF, 8'd0);
      chk("toggle_ff", q_out, 8'hF0);
      idle(1);

      // Count up across the wrap
      do_cmd(3'd1, 8'hFD, 8'd0);
      do_cmd(3'd5, 8'h00, 8'd5);
      chk("count_up_wrap", q_out, 8'h02);
      idle(1);

      // Count down across the wrap, zero-length count, reserved op, NOP
      do_cmd(3'd1, 8'h02, 8'd0);
      do_cmd(3'd6, 8'h00, 8'd3);
      chk("count_dn_wrap", q_out, 8'hFF);
      do_cmd(3'd5, 8'h55, 8'd0);
      chk("count_zero", q_out, 8'hFF);
      do_cmd(3'd7, 8'h55, 8'd9);
      do_cmd(3'd0, 8'hAA, 8'd9);
      idle(2);

      // Reset during COUNT_UP 10 at step 4
      do_cmd(3'd1, 8'h30, 8'd0);
      chk("ready_pre_rst", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = 3'd5;
      cmd_count = 8'd10;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int s = 0; s < 4; s++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("mid_q", q_out, 8'h34);
      chk("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_j", j_out, 8'h00);
      chk("mid_rst_k", k_out, 8'hFF);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q_model = 8'h00;
      chk("abort_q",     q_out,     8'h00);
      chk("abort_done",  done,      0);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_busy",  busy,      0);
      idle(3);

      // Randomized commands with random idle gaps
      for (int n = 0; n < 150; n++) begin
         do_cmd(3'($urandom), 8'($urandom), 8'($urandom_range(0, 12)));
         if ($urandom_range(0, 2) == 0) begin
            idle(int'($urandom_range(1, 2)));
         end
      end
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
